// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: operating modes
// and a small helper that turns the raw MODE bus into the mode type.
package universal_shift_register_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

    function automatic shift_mode_e decode_mode(input logic [1:0] mode);
        return shift_mode_e'(mode);
    endfunction

endpackage

// File: rtl/universal_shift_register_dff_bit.sv
// Single storage bit: D flip-flop with synchronous reset value and
// clock enable, driving true and complemented outputs.
module dff_bit #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_l
);

    // Reset wins over enable; otherwise capture d only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

    assign q_l = ~q;

endmodule

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: hold, shift right, shift left and
// parallel load, with optional rotate. Serial outputs expose the pre-edge
// end bits so instances cascade into a wider register.
module universal_shift_register
    import universal_shift_register_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter logic [31:0] RESET_VALUE = 32'd0,
    parameter bit          ROTATE      = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SI_R,
    input  logic             SI_L,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_L,
    output logic             SO_R,
    output logic             SO_L
);

    shift_mode_e      mode_sel;
    logic             shr_in;
    logic             shl_in;
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] q_l_bits;

    assign mode_sel = decode_mode(MODE);

    // In rotate mode the bit leaving one end re-enters at the other.
    assign shr_in = ROTATE ? q_bits[0]       : SI_R;
    assign shl_in = ROTATE ? q_bits[WIDTH-1] : SI_L;

    // Per-bit next-state selection; enable and reset are applied in the bits.
    always_comb begin
        d_next = q_bits;
        case (mode_sel)
            MODE_HOLD: d_next = q_bits;
            MODE_SHR:  d_next = {shr_in, q_bits[WIDTH-1:1]};
            MODE_SHL:  d_next = {q_bits[WIDTH-2:0], shl_in};
            MODE_LOAD: d_next = D;
            default:   d_next = q_bits;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit #(
            .RST_VAL (RESET_VALUE[i])
        ) u_bit (
            .clk (CLK),
            .rst (RST),
            .en  (EN),
            .d   (d_next[i]),
            .q   (q_bits[i]),
            .q_l (q_l_bits[i])
        );
    end

    assign Q    = q_bits;
    assign Q_L  = q_l_bits;
    assign SO_R = q_bits[0];
    assign SO_L = q_bits[WIDTH-1];

endmodule
